// File: rtl/mem_dec_pkg.sv
// Shared definitions for the memory region decoder: FSM states, access sizes
// and the default CPU memory map. Optional build macro: MEM_DEC_ALIGN_CHECK_EN.
package mem_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FAULT  = 2'd2
  } decStateT;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] DATA_BASE   = 32'h1001_0000;
  localparam logic [31:0] DATA_LIMIT  = 32'h1001_0FFF;
  localparam logic [31:0] STACK_BASE  = 32'h7FFF_EFFC;
  localparam logic [31:0] STACK_LIMIT = 32'h7FFF_FFFB;
  localparam logic [31:0] VGA_BASE    = 32'h0000_B800;
  localparam logic [31:0] VGA_LIMIT   = 32'h0000_CACF;
  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_LIMIT  = 32'hFFFF_000C;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_region_match.sv
// Combinational priority matcher: finds the lowest-index region containing
// vaddr and returns its index and the truncated offset from the region base.
module mem_region_match
  import mem_dec_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int PHYS_W = 13,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE =
    {MMIO_BASE, VGA_BASE, STACK_BASE, DATA_BASE},
  parameter logic [NUM_REGIONS*32-1:0] REGION_LIMIT =
    {MMIO_LIMIT, VGA_LIMIT, STACK_LIMIT, DATA_LIMIT},
  localparam int IDX_W = idxWidth(NUM_REGIONS)
) (
  input  logic [31:0]       vaddr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic [PHYS_W-1:0] offset
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    offset = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((vaddr >= REGION_BASE[32*i +: 32]) && (vaddr <= REGION_LIMIT[32*i +: 32])) begin
        hit    = 1'b1;
        idx    = IDX_W'(i);
        offset = PHYS_W'(vaddr - REGION_BASE[32*i +: 32]);
      end
    end
  end

endmodule

// File: rtl/mem_region_decoder.sv
// Registered memory region decoder between the load/store stage and the banks.
// Build macro MEM_DEC_ALIGN_CHECK_EN turns misaligned hits into faults.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | region enables driven, wait counter running to zero
// FAULT  | one-cycle unmapped-access report
module mem_region_decoder
  import mem_dec_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int PHYS_W = 13,
  parameter int BANK_W = 2,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE =
    {MMIO_BASE, VGA_BASE, STACK_BASE, DATA_BASE},
  parameter logic [NUM_REGIONS*32-1:0] REGION_LIMIT =
    {MMIO_LIMIT, VGA_LIMIT, STACK_LIMIT, DATA_LIMIT},
  parameter logic [NUM_REGIONS*BANK_W-1:0] REGION_BANK = {2'd2, 2'd1, 2'd0, 2'd0},
  parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = {4'd0, 4'd1, 4'd0, 4'd0}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic [31:0]            vaddr,
  output logic                   req_ready,
  output logic [PHYS_W-1:0]      phys_addr,
  output logic [NUM_REGIONS-1:0] mem_en,
  output logic [BANK_W-1:0]      mem_bank,
  output logic                   mem_we,
  output logic                   acc_done,
  output logic                   fault,
  output logic [31:0]            fault_addr,
  output logic                   fault_sticky,
  input  logic                   fault_clr
);

  localparam int IDX_W = idxWidth(NUM_REGIONS);

  decStateT state, stateNext;
  logic [3:0]             waitCnt, waitCntNext;
  logic [PHYS_W-1:0]      physNext;
  logic [NUM_REGIONS-1:0] enNext, oneHot;
  logic [BANK_W-1:0]      bankNext;
  logic                   weNext;
  logic [31:0]            faultAddrNext;
  logic                   stickyNext;

  logic              hit;
  logic [IDX_W-1:0]  matchIdx;
  logic [PHYS_W-1:0] matchOffset;
  logic              reqOk;

  mem_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .PHYS_W      (PHYS_W),
    .REGION_BASE (REGION_BASE),
    .REGION_LIMIT(REGION_LIMIT)
  ) uMatch (
    .vaddr (vaddr),
    .hit   (hit),
    .idx   (matchIdx),
    .offset(matchOffset)
  );

`ifdef MEM_DEC_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (req_size == 2'd3) ||
                      ((req_size == SZ_HALF) && vaddr[0]) ||
                      ((req_size == SZ_WORD) && (vaddr[1:0] != 2'b00));
  assign reqOk = hit && !misaligned;
`else
  logic unusedSize;
  assign unusedSize = ^req_size;
  assign reqOk = hit;
`endif

  always_comb begin
    oneHot = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      oneHot[i] = (matchIdx == IDX_W'(i));
    end
  end

  assign req_ready = (state == IDLE);
  assign acc_done  = (state == ACCESS) && (waitCnt == 4'd0);
  assign fault     = (state == FAULT);

  always_comb begin
    stateNext     = state;
    waitCntNext   = waitCnt;
    physNext      = phys_addr;
    enNext        = mem_en;
    bankNext      = mem_bank;
    weNext        = mem_we;
    faultAddrNext = fault_addr;
    stickyNext    = fault_clr ? 1'b0 : fault_sticky;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (reqOk) begin
            stateNext   = ACCESS;
            waitCntNext = REGION_WAIT[int'(matchIdx)*4 +: 4];
            physNext    = matchOffset;
            enNext      = oneHot;
            bankNext    = REGION_BANK[int'(matchIdx)*BANK_W +: BANK_W];
            weNext      = req_write;
          end else begin
            stateNext     = FAULT;
            faultAddrNext = vaddr;
            stickyNext    = 1'b1;
            enNext        = '0;
            weNext        = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (waitCnt == 4'd0) begin
          stateNext = IDLE;
          enNext    = '0;
          weNext    = 1'b0;
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end
      FAULT: begin
        // A clear arriving during the report cycle must not erase the new fault.
        stateNext  = IDLE;
        stickyNext = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      waitCnt      <= 4'd0;
      phys_addr    <= '0;
      mem_en       <= '0;
      mem_bank     <= '0;
      mem_we       <= 1'b0;
      fault_addr   <= 32'd0;
      fault_sticky <= 1'b0;
    end else begin
      state        <= stateNext;
      waitCnt      <= waitCntNext;
      phys_addr    <= physNext;
      mem_en       <= enNext;
      mem_bank     <= bankNext;
      mem_we       <= weNext;
      fault_addr   <= faultAddrNext;
      fault_sticky <= stickyNext;
    end
  end

endmodule

// File: tb/tb_mem_region_decoder.sv
// Self-checking bench for mem_region_decoder: directed vector table, hand-written
// fault/reset sequences and randomized requests against a memory-map model.
module tb_mem_region_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] vaddr = 32'd0;
  logic        fault_clr = 1'b0;
  logic        req_ready, mem_we, acc_done, fault, fault_sticky;
  logic [12:0] phys_addr;
  logic [3:0]  mem_en;
  logic [1:0]  mem_bank;
  logic [31:0] fault_addr;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] expFaultAddr = 32'd0;
  logic        expSticky = 1'b0;

`ifdef MEM_DEC_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic [31:0] mapBase  [4] = '{32'h10010000, 32'h7FFFEFFC, 32'h0000B800, 32'hFFFF0000};
  logic [31:0] mapLimit [4] = '{32'h10010FFF, 32'h7FFFFFFB, 32'h0000CACF, 32'hFFFF000C};
  logic [1:0]  mapBank  [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
  int          mapWait  [4] = '{0, 0, 1, 0};

  always #5 clk = ~clk;

  mem_region_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_size    (req_size),
    .vaddr       (vaddr),
    .req_ready   (req_ready),
    .phys_addr   (phys_addr),
    .mem_en      (mem_en),
    .mem_bank    (mem_bank),
    .mem_we      (mem_we),
    .acc_done    (acc_done),
    .fault       (fault),
    .fault_addr  (fault_addr),
    .fault_sticky(fault_sticky),
    .fault_clr   (fault_clr)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory map as a list of windows: first window containing the address wins.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz,
                                output logic h, output logic [3:0] en,
                                output logic [1:0] bank, output logic [12:0] phys,
                                output int w);
    h = 1'b0; en = '0; bank = '0; phys = '0; w = 0;
    for (int i = 0; i < 4; i++) begin
      if (!h && a >= mapBase[i] && a <= mapLimit[i]) begin
        h = 1'b1; en = 4'(1 << i); bank = mapBank[i];
        phys = 13'(a - mapBase[i]); w = mapWait[i];
      end
    end
    if (ALIGN_ON && h && (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00))) begin
      h = 1'b0; en = '0;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic doReq(input string tag, input logic [31:0] a, input logic w,
                       input logic [1:0] sz, input logic eHit, input logic [3:0] eEn,
                       input logic [1:0] eBank, input logic [12:0] ePhys, input int eWait);
    check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; vaddr = a;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_size = 2'($urandom); vaddr = $urandom;
    if (eHit) begin
      for (int c = 0; c <= eWait; c++) begin
        check({tag, " mem_en"},   32'(mem_en),    32'(eEn));
        check({tag, " mem_bank"}, 32'(mem_bank),  32'(eBank));
        check({tag, " phys"},     32'(phys_addr), 32'(ePhys));
        check({tag, " mem_we"},   32'(mem_we),    32'(w));
        check({tag, " ready_busy"}, 32'(req_ready), 32'd0);
        check({tag, " acc_done"}, 32'(acc_done),  32'(c == eWait));
        check({tag, " no_fault"}, 32'(fault),     32'd0);
        @(negedge clk);
      end
      check({tag, " en_off"},  32'(mem_en),    32'd0);
      check({tag, " we_off"},  32'(mem_we),    32'd0);
      check({tag, " done_off"}, 32'(acc_done), 32'd0);
    end else begin
      expFaultAddr = a;
      expSticky = 1'b1;
      check({tag, " fault"},      32'(fault),     32'd1);
      check({tag, " fault_en"},   32'(mem_en),    32'd0);
      check({tag, " fault_we"},   32'(mem_we),    32'd0);
      check({tag, " fault_busy"}, 32'(req_ready), 32'd0);
      check({tag, " fault_done"}, 32'(acc_done),  32'd0);
      check({tag, " fault_addr"}, fault_addr,     expFaultAddr);
      check({tag, " sticky"},     32'(fault_sticky), 32'd1);
      @(negedge clk);
      check({tag, " fault_pulse"}, 32'(fault), 32'd0);
    end
    check({tag, " ready_after"},  32'(req_ready),    32'd1);
    check({tag, " fault_addr_hold"}, fault_addr,     expFaultAddr);
    check({tag, " sticky_hold"},  32'(fault_sticky), 32'(expSticky));
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  sz;
    logic        hit;
    logic [3:0]  en;
    logic [1:0]  bank;
    logic [12:0] phys;
    int          waits;
  } vecT;

  vecT vecs[$];

  initial begin
    logic        mh;
    logic [3:0]  men;
    logic [1:0]  mb;
    logic [12:0] mp;
    int          mw;
    logic [31:0] a;
    logic [1:0]  sz;

    vecs.push_back('{"data_rd",   32'h10010010, 1'b0, 2'd2, 1'b1, 4'b0001, 2'd0, 13'h0010, 0});
    vecs.push_back('{"vga_wr",    32'h0000B804, 1'b1, 2'd2, 1'b1, 4'b0100, 2'd1, 13'h0004, 1});
    vecs.push_back('{"stack_rd",  32'h7FFFF000, 1'b0, 2'd2, 1'b1, 4'b0010, 2'd0, 13'h0004, 0});
    vecs.push_back('{"zero_miss", 32'h00000000, 1'b0, 2'd2, 1'b0, 4'b0000, 2'd0, 13'h0000, 0});
    vecs.push_back('{"data_top",  32'h10010FFF, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd0, 13'h0FFF, 0});
    vecs.push_back('{"data_past", 32'h10011000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 13'h0000, 0});
    vecs.push_back('{"mmio_top",  32'hFFFF000C, 1'b1, 2'd2, 1'b1, 4'b1000, 2'd2, 13'h000C, 0});
    vecs.push_back('{"mmio_past", 32'hFFFF000D, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 13'h0000, 0});
    vecs.push_back('{"vga_top",   32'h0000CACF, 1'b0, 2'd0, 1'b1, 4'b0100, 2'd1, 13'h12CF, 1});
    vecs.push_back('{"stack_top", 32'h7FFFFFFB, 1'b1, 2'd0, 1'b1, 4'b0010, 2'd0, 13'h0FFF, 0});
    vecs.push_back('{"vga_below", 32'h0000B7FF, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 13'h0000, 0});
    vecs.push_back('{"word_misal", 32'h10010002, 1'b0, 2'd2, !ALIGN_ON,
                     ALIGN_ON ? 4'b0000 : 4'b0001, 2'd0, 13'h0002, 0});

    // Reset state, sampled while reset is held.
    @(negedge clk);
    @(negedge clk);
    check("rst ready",  32'(req_ready), 32'd1);
    check("rst phys",   32'(phys_addr), 32'd0);
    check("rst en",     32'(mem_en),    32'd0);
    check("rst bank",   32'(mem_bank),  32'd0);
    check("rst we",     32'(mem_we),    32'd0);
    check("rst done",   32'(acc_done),  32'd0);
    check("rst fault",  32'(fault),     32'd0);
    check("rst faddr",  fault_addr,     32'd0);
    check("rst sticky", 32'(fault_sticky), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      doReq(vecs[k].name, vecs[k].addr, vecs[k].wr, vecs[k].sz, vecs[k].hit,
            vecs[k].en, vecs[k].bank, vecs[k].phys, vecs[k].waits);
      if (k[0]) @(negedge clk);
    end

    // fault_clr alone clears the sticky flag.
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    expSticky = 1'b0;
    check("clr sticky", 32'(fault_sticky), 32'd0);
    check("clr faddr_kept", fault_addr, expFaultAddr);

    // fault_clr on the same edge as a new miss: the set wins.
    fault_clr = 1'b1; req_valid = 1'b1; vaddr = 32'h00000020; req_size = 2'd0;
    @(negedge clk);
    fault_clr = 1'b0; req_valid = 1'b0;
    expFaultAddr = 32'h00000020; expSticky = 1'b1;
    check("coinc fault",  32'(fault),        32'd1);
    check("coinc sticky", 32'(fault_sticky), 32'd1);
    check("coinc faddr",  fault_addr,        32'h00000020);
    @(negedge clk);
    check("coinc sticky_hold", 32'(fault_sticky), 32'd1);
    check("coinc ready", 32'(req_ready), 32'd1);

    // Reset during a VGA access drops enables at once and never completes it.
    req_valid = 1'b1; req_write = 1'b1; vaddr = 32'h0000B800; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid en_before", 32'(mem_en), 32'b0100);
    check("rstmid done_before", 32'(acc_done), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rstmid en_async",   32'(mem_en),    32'd0);
    check("rstmid we_async",   32'(mem_we),    32'd0);
    check("rstmid done_async", 32'(acc_done),  32'd0);
    check("rstmid ready",      32'(req_ready), 32'd1);
    check("rstmid sticky",     32'(fault_sticky), 32'd0);
    expSticky = 1'b0; expFaultAddr = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rstmid no_done", 32'(acc_done), 32'd0);
      check("rstmid en_idle", 32'(mem_en),   32'd0);
      @(negedge clk);
    end

    // Randomized requests against the memory-map model.
    for (int n = 0; n < 80; n++) begin
      int i;
      i = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0: a = mapBase[i] + 32'($urandom_range(0, 15));
        1: a = mapLimit[i] - 32'($urandom_range(0, 3));
        2: a = mapLimit[i] + 32'($urandom_range(1, 2));
        3: a = mapBase[i] - 32'd1;
        default: a = $urandom;
      endcase
      sz = 2'($urandom_range(0, 3));
      model(a, sz, mh, men, mb, mp, mw);
      doReq($sformatf("rnd%0d", n), a, 1'($urandom), sz, mh, men, mb, mp, mw);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_region_decoder.md
Name: mem_region_decoder

Overview:
Parametrised, registered successor to the CPU's combinational memory decoder. It sits between the MIPS32 core's load/store stage and the memory banks (data RAM, VGA RAM, MMIO). It accepts one request at a time through a valid/ready handshake and matches the virtual address against N configurable regions. It drives a one-hot enable, a bank select and an offset physical address for a configurable number of wait states, then acknowledges. On a miss it raises a fault and captures the faulting address.

Parameters:
NUM_REGIONS, 4, number of address windows (1..8)
PHYS_W, 13, physical address width
BANK_W, 2, bank select width
REGION_BASE, {32'hFFFF0000,32'h0000B800,32'h7FFFEFFC,32'h10010000}, packed NUM_REGIONS*32; region i at bits [32i+31:32i]
REGION_LIMIT, {32'hFFFF000C,32'h0000CACF,32'h7FFFFFFB,32'h10010FFF}, packed inclusive upper bounds
REGION_BANK, {2'd2,2'd1,2'd0,2'd0}, packed NUM_REGIONS*BANK_W bank id per region
REGION_WAIT, {4'd0,4'd1,4'd0,4'd0}, packed NUM_REGIONS*4 wait states per region (0..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_write  in  1  1=store, 0=load; sampled with req_valid
req_size  in  2  0=byte, 1=half, 2=word
vaddr  in  32  virtual address
req_ready  out  1  decoder can accept a request (high only in IDLE)
phys_addr  out  PHYS_W  registered (vaddr - base)[PHYS_W-1:0]
mem_en  out  NUM_REGIONS  one-hot region enable, registered
mem_bank  out  BANK_W  bank select, registered
mem_we  out  1  write strobe, registered
acc_done  out  1  one-cycle pulse on the last access cycle
fault  out  1  one-cycle pulse on an unmapped access
fault_addr  out  32  vaddr of the most recent fault
fault_sticky  out  1  set by a fault, held until fault_clr
fault_clr  in  1  clears fault_sticky

Behaviour:
- Reset, asynchronous: state=IDLE; req_ready=1; phys_addr=0; mem_en=0; mem_bank=0; mem_we=0; acc_done=0; fault=0; fault_addr=0; fault_sticky=0; wait counter=0.
- Handshake: a request is accepted when req_valid&&req_ready. Inputs are sampled only on acceptance and may change afterwards.
- Match: region i hits if REGION_BASE[i] <= vaddr <= REGION_LIMIT[i], using unsigned 32-bit compares. On overlap the lowest index wins.
- IDLE→ACCESS on a hit. Next cycle: mem_en=one-hot(i), mem_bank=REGION_BANK[i], phys_addr=(vaddr-base)[PHYS_W-1:0] truncated, mem_we=req_write. Counter loads REGION_WAIT[i].
- ACCESS: outputs are held. Counter decrements each cycle. When the counter is 0, acc_done=1 for that cycle, and the next state is IDLE with mem_en=0 and mem_we=0. Zero wait states give exactly 1 ACCESS cycle, so request-to-acc_done latency is 1 clock. W wait states give W+1 cycles.
- IDLE→FAULT on a miss. FAULT lasts one cycle: fault=1, fault_addr=vaddr, fault_sticky=1, mem_en=0, mem_we=0. Then back to IDLE.
- req_ready=0 in ACCESS and FAULT, so back-to-back requests cost at least 1 idle cycle.
- fault_clr: clears fault_sticky. If fault_clr coincides with a new fault, set wins.
- An ACCESS with a wait count of 15 must not wrap; the counter saturates at 0.
- A reset mid-ACCESS drops mem_en immediately, and no acc_done is issued.

Optional Feature:
MEM_DEC_ALIGN_CHECK_EN
- Defined: a hit with a misaligned address is treated as a fault (FAULT state, fault_addr captured). Misaligned means half with vaddr[0]=1, or word with vaddr[1:0]!=0. req_size=3 also faults.
- Undefined: req_size is ignored and alignment is not checked.

Decomposition:
- Shared package mem_dec_pkg holds:
  - the state encoding (IDLE, ACCESS, FAULT);
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the default region base/limit constants (DATA, STACK, VGA, MMIO).
- One sub-module, mem_region_match: combinational priority matcher with inputs vaddr and the parameters, and outputs hit, index and offset. It is reused by the future instruction-fetch decoder.

Test Plan:
- Read vaddr=32'h10010010, default params → next cycle mem_en=4'b0001, mem_bank=0, phys_addr=13'h0010, mem_we=0; acc_done pulses on that same cycle.
- Write vaddr=32'h0000B804, VGA region with 1 wait state → mem_en=4'b0100, phys_addr=13'h0004, mem_we=1 for 2 cycles; acc_done on the 2nd cycle; req_ready=0 throughout.
- Read vaddr=32'h7FFFF000 → mem_en=4'b0010, mem_bank=0, phys_addr=13'h0004.
- Read vaddr=32'h00000000 → fault pulses 1 cycle, fault_addr=32'h00000000, fault_sticky=1, mem_en stays 0. Assert fault_clr → sticky=0; then fault_clr coinciding with a new fault → sticky stays 1.
- Boundaries: 32'h10010FFF hits; 32'h10011000 faults; 32'hFFFF000C hits; 32'hFFFF000D faults.
- With MEM_DEC_ALIGN_CHECK_EN, a word read at 32'h10010002 → fault. Assert rst during a VGA ACCESS → mem_en=0 asynchronously and no acc_done.
